// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer and its reference model.
package gate_seq_pkg;

  localparam int MAX_N_IN = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_vector_sequencer_ref.sv
// gate_ref_model: combinational expected-output function, a reduction of stim selected by OP.
module gate_ref_model
  import gate_seq_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int OP   = 0
) (
  input  logic [N_IN-1:0] stim,
  output logic            exp_bit
);

  localparam op_e OP_SEL = op_e'(OP[1:0]);

  always_comb begin
    exp_bit = &stim;
    case (OP_SEL)
      OP_AND:  exp_bit = &stim;
      OP_OR:   exp_bit = |stim;
      OP_XOR:  exp_bit = ^stim;
      OP_NAND: exp_bit = ~&stim;
      default: exp_bit = &stim;
    endcase
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive stimulus sweep plus response check for a small combinational gate.
// Optional per-vector response capture is enabled by defining GATE_SEQ_LOG_EN.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int HOLD = 5,
  parameter int OP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_out,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt
`ifdef GATE_SEQ_LOG_EN
  ,
  output logic [2**N_IN-1:0] result_log
`endif
);

  localparam int          EW        = N_IN + 1;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD - 1);

  state_e     state;
  logic [7:0] hold_cnt;
  logic       exp_bit;
  logic       sample;
  logic       mismatch;

  gate_ref_model #(
    .N_IN (N_IN),
    .OP   (OP)
  ) u_ref (
    .stim    (stim),
    .exp_bit (exp_bit)
  );

  // dut_out is used unregistered: the gate settles within the hold window.
  assign sample   = (state == DRIVE) && (hold_cnt == HOLD_LAST);
  assign mismatch = (dut_out != exp_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stim     <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= DRIVE;
            stim     <= '0;
            hold_cnt <= '0;
            err_cnt  <= '0;
          end
        end
        DRIVE: begin
          if (sample) begin
            if (mismatch && !(&err_cnt))
              err_cnt <= err_cnt + EW'(1);
            hold_cnt <= '0;
            // Final vector stays on stim after the sweep ends.
            if (&stim)
              state <= DONE;
            else
              stim <= stim + N_IN'(1);
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == DRIVE);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

`ifdef GATE_SEQ_LOG_EN
  always_ff @(posedge clk) begin
    if (rst)
      result_log <= '0;
    else if (start && (state != DRIVE))
      result_log <= '0;
    else if (sample)
      result_log[stim] <= dut_out;
  end
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: cycle model compared every cycle, plus directed literal checks.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  int         mode1 = 0;          // 0 = correct AND, 1 = stuck-at-1, 2 = OR gate

  logic [1:0] stim1;
  logic       busy1, done1, pass1, dut_out1;
  logic [2:0] err1;
  logic [2:0] stim3;
  logic       busy3, done3, pass3, dut_out3;
  logic [3:0] err3;
`ifdef GATE_SEQ_LOG_EN
  logic [3:0] log1;
  logic [7:0] log3;
`endif

  assign dut_out1 = (mode1 == 0) ? (&stim1) : (mode1 == 1) ? 1'b1 : (|stim1);
  assign dut_out3 = ^stim3;

  gate_vector_sequencer #(.N_IN(2), .HOLD(5), .OP(0)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .dut_out    (dut_out1),
    .stim       (stim1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_cnt    (err1)
`ifdef GATE_SEQ_LOG_EN
    ,
    .result_log (log1)
`endif
  );

  gate_vector_sequencer #(.N_IN(3), .HOLD(1), .OP(2)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .dut_out    (dut_out3),
    .stim       (stim3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_cnt    (err3)
`ifdef GATE_SEQ_LOG_EN
    ,
    .result_log (log3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference output of the gate function over vector value k.
  function automatic int ref_bit(input int op, input int n, input int k);
    int all1;
    all1 = (1 << n) - 1;
    case (op)
      0:       return (k == all1) ? 1 : 0;
      1:       return (k != 0) ? 1 : 0;
      2:       return $countones(k) % 2;
      default: return (k != all1) ? 1 : 0;
    endcase
  endfunction

  function automatic int dut_bit(input int mode, input int op, input int n, input int k);
    case (mode)
      1:       return 1;
      2:       return (k != 0) ? 1 : 0;
      default: return ref_bit(op, n, k);
    endcase
  endfunction

  // t = cycle index since the start edge (t=1 is first DRIVE cycle); t<1 means idle.
  task automatic model(input int t, input int n, input int hold, input int op, input int mode,
                       output int es, output int eb, output int ed, output int ee);
    int total;
    total = (1 << n) * hold;
    es = 0; eb = 0; ed = 0; ee = 0;
    if (t >= 1) begin
      for (int k = 0; k < (1 << n); k++)
        if (((k + 1) * hold < t) && (dut_bit(mode, op, n, k) != ref_bit(op, n, k)))
          ee++;
      if (t <= total) begin
        es = (t - 1) / hold;
        eb = 1;
      end else begin
        es = (1 << n) - 1;
        ed = 1;
      end
    end
  endtask

  int t1 = -1, t3 = -1;
  int mode1_s = 0;

  always @(posedge clk) begin
    if (rst) begin
      t1 <= -1;
      t3 <= -1;
    end else begin
      if (start1 && (t1 < 1 || t1 > 20)) begin
        t1      <= 1;
        mode1_s <= mode1;
      end else if (t1 >= 1 && t1 <= 20) begin
        t1 <= t1 + 1;
      end
      if (start3 && (t3 < 1 || t3 > 8))
        t3 <= 1;
      else if (t3 >= 1 && t3 <= 8)
        t3 <= t3 + 1;
    end
  end

  always @(negedge clk) begin
    int es, eb, ed, ee;
    if (chk_en) begin
      model(t1, 2, 5, 0, mode1_s, es, eb, ed, ee);
      check("m1_stim", int'(stim1), es);
      check("m1_busy", int'(busy1), eb);
      check("m1_done", int'(done1), ed);
      check("m1_err",  int'(err1),  ee);
      check("m1_pass", int'(pass1), (ed == 1 && ee == 0) ? 1 : 0);
      model(t3, 3, 1, 2, 0, es, eb, ed, ee);
      check("m3_stim", int'(stim3), es);
      check("m3_busy", int'(busy3), eb);
      check("m3_done", int'(done3), ed);
      check("m3_err",  int'(err3),  ee);
      check("m3_pass", int'(pass3), (ed == 1 && ee == 0) ? 1 : 0);
    end
  end

  // Starts a sweep on dut1, optionally pulses start at edge pulse_c+1, returns done latency.
  task automatic sweep1(input int pulse_c, output int lat);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 1;
    check("c1_busy", int'(busy1), 1);
    check("c1_stim", int'(stim1), 0);
    check("c1_err",  int'(err1),  0);
    check("c1_done", int'(done1), 0);
    while (!done1 && lat < 200) begin
      start1 = (lat == pulse_c);
      @(negedge clk);
      start1 = 1'b0;
      lat++;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_stim", int'(stim1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_pass", int'(pass1), 0);
    check("rst_err",  int'(err1),  0);
    repeat (2) @(negedge clk);

    // Correct AND gate, with an ignored start pulse mid-sweep.
    mode1 = 0;
    sweep1(9, lat);
    check("and_done_latency", lat, 21);
    check("and_err", int'(err1), 0);
    check("and_pass", int'(pass1), 1);
    repeat (3) @(negedge clk);

    // Stuck-at-1 DUT, restarted straight from DONE.
    mode1 = 1;
    sweep1(-1, lat);
    check("sa1_done_latency", lat, 21);
    check("sa1_err", int'(err1), 3);
    check("sa1_pass", int'(pass1), 0);
    check("sa1_done", int'(done1), 1);
    repeat (2) @(negedge clk);

    // Reset taken at edge 8 of a sweep.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_err", int'(err1), 1);
    check("pre_rst_stim", int'(stim1), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_stim", int'(stim1), 0);
    check("mid_rst_busy", int'(busy1), 0);
    check("mid_rst_err",  int'(err1),  0);
    check("mid_rst_done", int'(done1), 0);
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy1), 0);

    // Single-cycle hold, 3-input XOR.
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 1;
    while (!done3 && lat < 200) begin
      check("x3_stim_step", int'(stim3), lat - 1);
      @(negedge clk);
      lat++;
    end
    check("x3_done_latency", lat, 9);
    check("x3_pass", int'(pass3), 1);
    check("x3_stim_final", int'(stim3), 7);
    repeat (2) @(negedge clk);

    // OR gate against the AND reference: vectors 1 and 2 disagree.
    mode1 = 2;
    sweep1(-1, lat);
    check("or_done_latency", lat, 21);
    check("or_err", int'(err1), 2);
`ifdef GATE_SEQ_LOG_EN
    check("or_result_log", int'(log1), 4'b1110);
    check("x3_result_log", int'(log3), 8'b1001_0110);
`endif
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
